lsu_controller: RTL
===================

// Module: lsu_controller
// PURPOSE
//  Sequences one load/store at a time between the MEM stage and the data-memory bus.
//  Decodes access_type (common package: LB/LH/LW/LBU/LHU/SB/SH/SW) and checks alignment.
//  Drives a valid/ready bus with byte-lane strobes, enforces a bus timeout and
//  returns sign/zero-extended load data through a response handshake.
// PARAMETERS
//  TIMEOUT_CYCLES  64  cycles in BUS without mem_ready before a bus error; 0 = no timeout
// PORTS
//  clk            in   1   clock, rising edge
//  rst            in   1   asynchronous, active-high reset
//  req_valid      in   1   MEM stage presents an access
//  req_ready      out  1   controller accepts (IDLE only)
//  access_type    in   4   common-package access encoding
//  req_addr       in   32  byte address
//  req_wdata      in   32  store data, right-aligned
//  resp_valid     out  1   access complete; held until resp_ready
//  resp_ready     in   1   MEM stage consumes response
//  resp_rdata     out  32  extended load data (0 for stores/errors)
//  resp_err       out  1   access faulted
//  resp_cause     out  2   0 none, 1 misaligned, 2 bus timeout
//  mem_valid      out  1   bus request active
//  mem_we         out  1   1 = write
//  mem_addr       out  32  word address {addr[31:2],2'b00}
//  mem_wstrb      out  4   byte-lane enables (write only, else 0)
//  mem_wdata      out  32  req_wdata << 8*addr[1:0]
//  mem_ready      in   1   bus completes; mem_rdata valid same cycle for reads
//  mem_rdata      in   32  read word
// BEHAVIOUR
//  States: IDLE, BUS, RESP. Reset (async) -> IDLE. All outputs 0 while rst is high.
//  - IDLE: req_ready=1. On req_valid&req_ready, latch type/addr/wdata:
//    - Non-memory type: RESP, err=0, rdata=0, no bus cycle.
//    - Misaligned (H with addr[0]=1, W with addr[1:0]!=0): RESP, err=1, cause=1, no bus cycle.
//    - Otherwise: BUS, timeout counter cleared.
//  - BUS: mem_valid=1. Addr, we, wstrb and wdata are stable until mem_ready.
//    - Strobes: B=4'b0001<<a[1:0], H=4'b0011<<a[1:0], W=4'b1111.
//    - On mem_ready: -> RESP. A load registers its extracted data.
//    - Counter increments each BUS cycle without mem_ready. When it reaches
//      TIMEOUT_CYCLES: mem_valid drops, -> RESP, err=1, cause=2.
//    - mem_ready in the timeout cycle wins (normal completion).
//  - Load extract: s = mem_rdata >> 8*a[1:0].
//    - LB = sext(s[7:0]), LBU = zext(s[7:0]), LH/LHU likewise on s[15:0], LW = mem_rdata.
//  - RESP: resp_valid=1, resp_* registered and stable. On resp_ready -> IDLE.
//    - req_ready=0, so no back-to-back overlap.
//    - Min latency: aligned access with mem_ready in first BUS cycle ->
//      accept t0, mem_valid t1, resp_valid t2. Next accept possible t3.
//  - Reset mid-BUS: mem_valid drops asynchronously. The bus must tolerate an abandoned request.
//  - req_valid outside IDLE is ignored (not latched). mem_ready outside BUS is ignored.
//  - Counter is $clog2(TIMEOUT_CYCLES+1) bits wide and saturates; it never wraps.
// TESTING
//  1. LB addr=0x1003, mem_rdata=0x80112233, ready in 1st BUS cycle
//     -> mem_addr=0x1000, wstrb=0, resp_rdata=0xFFFFFF80, resp_valid at t2.
//  2. SH addr=0x2002, wdata=0x0000ABCD -> mem_we=1, wstrb=4'b1100,
//     mem_wdata=0xABCD0000; resp_err=0, rdata=0.
//  3. LW addr=0x3001 -> no mem_valid ever; resp_err=1, resp_cause=1 one cycle after accept.
//  4. LHU addr=0x4002, mem_ready never, TIMEOUT_CYCLES=4
//     -> mem_valid high exactly 4 cycles, then resp_cause=2.
//  5. resp_ready held low 3 cycles -> resp_* stable, req_ready=0; new req accepted the cycle after resp_ready.
//  6. rst asserted mid-BUS -> mem_valid, resp_valid = 0 immediately; after release req_ready=1, state IDLE.

Source files
------------

// File: rtl/lsu_controller.sv
// Load/store sequencer between the MEM stage and a valid/ready data-memory bus.
// Handles one access at a time: decode, alignment check, bus cycle with timeout, extended response.
module lsu_controller #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  access_type,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [1:0]  resp_cause,
  output logic        mem_valid,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);
  localparam logic [3:0] T_LB  = 4'h0;
  localparam logic [3:0] T_LH  = 4'h1;
  localparam logic [3:0] T_LW  = 4'h2;
  localparam logic [3:0] T_LBU = 4'h4;
  localparam logic [3:0] T_LHU = 4'h5;
  localparam logic [3:0] T_SB  = 4'h8;
  localparam logic [3:0] T_SH  = 4'h9;
  localparam logic [3:0] T_SW  = 4'hA;

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [CW-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic [1:0]    cause_q, cause_d;
  logic [3:0]    type_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;

  function automatic logic is_load(input logic [3:0] t);
    return (t == T_LB) || (t == T_LH) || (t == T_LW) || (t == T_LBU) || (t == T_LHU);
  endfunction

  function automatic logic is_store(input logic [3:0] t);
    return (t == T_SB) || (t == T_SH) || (t == T_SW);
  endfunction

  // Size lives in t[1:0] for both loads and stores: 0 byte, 1 half, 2 word.
  function automatic logic misaligned(input logic [3:0] t, input logic [1:0] a);
    return ((t[1:0] == 2'd1) && a[0]) || ((t[1:0] == 2'd2) && (a != 2'd0));
  endfunction

  function automatic logic [31:0] extract(input logic [3:0] t, input logic [1:0] a,
                                          input logic [31:0] word);
    logic [31:0] s;
    s = word >> {a, 3'b000};
    case (t)
      T_LB:    return {{24{s[7]}}, s[7:0]};
      T_LBU:   return {24'h0, s[7:0]};
      T_LH:    return {{16{s[15]}}, s[15:0]};
      T_LHU:   return {16'h0, s[15:0]};
      default: return word;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cause_q <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cause_q <= cause_d;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && req_valid) begin
      type_q  <= access_type;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cause_d = cause_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          rdata_d = '0;
          err_d   = 1'b0;
          cause_d = 2'd0;
          cnt_d   = '0;
          if (!is_load(access_type) && !is_store(access_type)) begin
            state_d = S_RESP;
          end else if (misaligned(access_type, req_addr[1:0])) begin
            state_d = S_RESP;
            err_d   = 1'b1;
            cause_d = 2'd1;
          end else begin
            state_d = S_BUS;
          end
        end
      end
      S_BUS: begin
        // A completion in the same cycle as the timeout takes priority.
        if (mem_ready) begin
          state_d = S_RESP;
          rdata_d = is_load(type_q) ? extract(type_q, addr_q[1:0], mem_rdata) : '0;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
          state_d = S_RESP;
          err_d   = 1'b1;
          cause_d = 2'd2;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_err   = 1'b0;
    resp_cause = 2'd0;
    mem_valid  = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wstrb  = '0;
    mem_wdata  = '0;
    case (state_q)
      S_IDLE: req_ready = !rst;
      S_BUS: begin
        mem_valid = 1'b1;
        mem_we    = is_store(type_q);
        mem_addr  = {addr_q[31:2], 2'b00};
        mem_wdata = wdata_q << {addr_q[1:0], 3'b000};
        if (is_store(type_q)) begin
          case (type_q[1:0])
            2'd0:    mem_wstrb = 4'b0001 << addr_q[1:0];
            2'd1:    mem_wstrb = 4'b0011 << addr_q[1:0];
            default: mem_wstrb = 4'b1111;
          endcase
        end
      end
      S_RESP: begin
        resp_valid = 1'b1;
        resp_rdata = rdata_q;
        resp_err   = err_q;
        resp_cause = cause_q;
      end
      default: ;
    endcase
  end
endmodule
